pipe_skid_reg: RTL
==================

// Module: pipe_skid_reg
// PURPOSE
//  Parametrised pipeline stage register with valid/ready flow control, synchronous flush
//  and an optional skid entry. Replaces fixed per-stage registers (IF/ID, ID/EX, EX/MEM,
//  MEM/WB) with one block carrying an arbitrary packed payload. Stalls propagate without
//  combinational ready paths, and flushed or empty slots present an all-zero bubble.
// PARAMETERS
//  PAYLOAD_W  37  payload width in bits (MEM/WB: 1 mem_to_reg + 4 wb_dst + 16 mem_data + 16 alu_result)
//  SKID_EN    1   1: two entries (main + skid), registered i_ready; 0: one entry, i_ready = !o_valid | i_ready_dn
// PORTS
//  clk         in   1          single clock, rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  clear       in   1          synchronous flush; highest priority after reset
//  i_valid     in   1          upstream presents i_payload
//  i_payload   in   PAYLOAD_W  upstream stage fields, packed
//  o_ready     out  1          stage can accept i_payload this cycle
//  o_valid     out  1          o_payload is valid for the downstream stage
//  o_payload   out  PAYLOAD_W  head entry; all zeros whenever o_valid=0
//  i_ready_dn  in   1          downstream accepts o_payload this cycle
//  o_count     out  2          occupancy: 0, 1 or 2 (2 only when SKID_EN=1)
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Transfers: upstream transfer when i_valid & o_ready; downstream transfer when o_valid & i_ready_dn.
//  - Reset (rst_n=0, async): state EMPTY, main=0, skid=0, o_valid=0, o_payload=0, o_count=0.
//    o_ready=1 while rst_n=0.
//  - clear=1 at a rising edge:
//    - Next state EMPTY, main and skid zeroed.
//    - Any same-cycle input is dropped, and any same-cycle output transfer counts as a
//      non-event.
//  - States (SKID_EN=1):
//    - EMPTY (o_valid=0, o_ready=1, count 0): i_valid -> FULL, main<=i_payload.
//    - FULL  (o_valid=1, o_ready=1, count 1):
//      - i_valid & i_ready_dn -> FULL, main<=i_payload (same-cycle pass-through).
//      - i_valid & !i_ready_dn -> SKID, skid<=i_payload.
//      - !i_valid & i_ready_dn -> EMPTY, main<=0.
//      - Otherwise hold.
//    - SKID  (o_valid=1, o_ready=0, count 2):
//      - i_ready_dn -> FULL, main<=skid, skid<=0.
//      - Otherwise hold.
//      - i_valid is ignored.
//  - o_ready is a pure function of registered state (no i_ready_dn -> o_ready path) when SKID_EN=1.
//  - SKID_EN=0: states EMPTY/FULL only.
//    - o_ready = !o_valid | i_ready_dn (combinational).
//    - Accepted input loads main.
//    - Output transfer with no input returns the stage to EMPTY with main<=0.
//  - Latency: 1 cycle from upstream transfer to o_valid when the stage is EMPTY.
//  - Throughput: 1 transfer/cycle sustained while i_ready_dn=1.
//  - Ordering is strict FIFO; payload is never duplicated, dropped (except on clear) or modified.
//  - i_payload is sampled only on an upstream transfer.
//  - While o_valid=1 and i_ready_dn=0, o_payload is held stable.
// STRUCTURE
//  - Shared package pipe_pkg:
//    - state enum {PS_EMPTY, PS_FULL, PS_SKID}.
//    - Per-stage payload width constants (IFID_W, IDEX_W, EXMEM_W, MEMWB_W=37).
//    - Pack/unpack field offsets for each stage.
//  - No sub-module: a single block holding the state register plus the main and skid
//    data registers.
//  - Stage wrappers (e.g. the MEM/WB stage) pack fields into i_payload and unpack o_payload.
// TESTING
//  1. Reset then stream: rst_n low 2 cycles, then i_valid=1, payload 0x1_5_ABCD_1234, i_ready_dn=1
//     -> o_valid=1 next cycle, o_payload matches, o_count=1.
//  2. Backpressure: FULL with A, i_ready_dn=0, send B -> count=2, o_ready=0, o_payload=A;
//     raise i_ready_dn -> A out, then B out next cycle, count 2->1->0.
//  3. Flush: count=2, clear=1 with i_valid=1 for one cycle -> next cycle count=0, o_valid=0,
//     o_payload=0, o_ready=1; the dropped input never appears.
//  4. Async reset mid-transfer: assert rst_n=0 between clock edges while count=2 -> o_valid,
//     o_count and o_payload are 0 immediately, before the next edge.
//  5. Random valid/ready (10k cycles, both SKID_EN values) vs a FIFO scoreboard:
//    - In-order, lossless delivery.
//    - o_payload stable while stalled.
//    - o_payload=0 whenever o_valid=0.
//  6. SKID_EN=0, FULL, i_ready_dn=1, i_valid=1 each cycle -> 1 transfer/cycle,
//     o_ready=1 every cycle, count stays 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: occupancy states,
// per-stage payload widths and the field layout used to pack/unpack payloads.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_FULL  = 2'd1,
        PS_SKID  = 2'd2
    } pipe_state_e;

    // IF/ID: {pc[15:0], instr[15:0]}
    localparam int IFID_W          = 32;
    localparam int IFID_INSTR_LSB  = 0;
    localparam int IFID_PC_LSB     = 16;

    // ID/EX: {ctrl[7:0], wb_dst[3:0], imm[15:0], rs2_val[15:0], rs1_val[15:0]}
    localparam int IDEX_W          = 60;
    localparam int IDEX_RS1_LSB    = 0;
    localparam int IDEX_RS2_LSB    = 16;
    localparam int IDEX_IMM_LSB    = 32;
    localparam int IDEX_DST_LSB    = 48;
    localparam int IDEX_CTRL_LSB   = 52;

    // EX/MEM: {ctrl[3:0], wb_dst[3:0], store_data[15:0], alu_result[15:0]}
    localparam int EXMEM_W         = 40;
    localparam int EXMEM_ALU_LSB   = 0;
    localparam int EXMEM_STORE_LSB = 16;
    localparam int EXMEM_DST_LSB   = 32;
    localparam int EXMEM_CTRL_LSB  = 36;

    // MEM/WB: {mem_to_reg, wb_dst[3:0], mem_data[15:0], alu_result[15:0]}
    localparam int MEMWB_W         = 37;
    localparam int MEMWB_ALU_LSB   = 0;
    localparam int MEMWB_MDATA_LSB = 16;
    localparam int MEMWB_DST_LSB   = 32;
    localparam int MEMWB_M2R_BIT   = 36;

    // Occupancy reported for each state.
    function automatic logic [1:0] state_count(input pipe_state_e st);
        logic [1:0] cnt;
        case (st)
            PS_EMPTY: cnt = 2'd0;
            PS_FULL:  cnt = 2'd1;
            PS_SKID:  cnt = 2'd2;
            default:  cnt = 2'd0;
        endcase
        return cnt;
    endfunction

    // Pack the MEM/WB fields into a stage payload.
    function automatic logic [MEMWB_W-1:0] pack_memwb(
        input logic        mem_to_reg,
        input logic [3:0]  wb_dst,
        input logic [15:0] mem_data,
        input logic [15:0] alu_result
    );
        return {mem_to_reg, wb_dst, mem_data, alu_result};
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle between a pipeline stage register and its
// upstream/downstream neighbours.
interface pipe_skid_reg_if #(
    parameter int PAYLOAD_W = 37
);
    logic                 i_valid;
    logic [PAYLOAD_W-1:0] i_payload;
    logic                 o_ready;
    logic                 o_valid;
    logic [PAYLOAD_W-1:0] o_payload;
    logic                 i_ready_dn;
    logic [1:0]           o_count;

    // The environment around the stage drives inputs and observes outputs.
    modport master (
        output i_valid, i_payload, i_ready_dn,
        input  o_ready, o_valid, o_payload, o_count
    );

    // The stage register itself.
    modport slave (
        input  i_valid, i_payload, i_ready_dn,
        output o_ready, o_valid, o_payload, o_count
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready flow control, synchronous flush and
// an optional skid entry. Empty or flushed slots present an all-zero payload.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = MEMWB_W,
    parameter bit SKID_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    pipe_skid_reg_if.slave   bus
);

    pipe_state_e          r_state;
    logic [PAYLOAD_W-1:0] r_main;
    logic [PAYLOAD_W-1:0] r_skid;

    // Outputs decode straight from registers; r_main is kept zero whenever
    // the stage is empty so the bubble needs no output mux.
    assign bus.o_valid   = (r_state != PS_EMPTY);
    assign bus.o_payload = r_main;
    assign bus.o_count   = state_count(r_state);

    generate
        if (SKID_EN) begin : g_ready_skid
            // Ready depends only on state: the skid entry absorbs the one
            // extra word that may arrive while the stall propagates upstream.
            assign bus.o_ready = (r_state != PS_SKID);
        end else begin : g_ready_noskid
            // Single entry: accept when empty or when the head leaves now.
            assign bus.o_ready = (r_state == PS_EMPTY) | bus.i_ready_dn;
        end
    endgenerate

    // Occupancy FSM and data registers; flush beats every transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PS_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (clear) begin
            r_state <= PS_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (bus.i_valid) begin
                        r_state <= PS_FULL;
                        r_main  <= bus.i_payload;
                    end else begin
                        r_state <= PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (bus.i_valid && bus.i_ready_dn) begin
                        // Head leaves and the new word replaces it.
                        r_state <= PS_FULL;
                        r_main  <= bus.i_payload;
                    end else if (bus.i_valid && SKID_EN) begin
                        r_state <= PS_SKID;
                        r_skid  <= bus.i_payload;
                    end else if (bus.i_ready_dn) begin
                        r_state <= PS_EMPTY;
                        r_main  <= '0;
                    end else begin
                        r_state <= PS_FULL;
                    end
                end
                PS_SKID: begin
                    if (bus.i_ready_dn) begin
                        r_state <= PS_FULL;
                        r_main  <= r_skid;
                        r_skid  <= '0;
                    end else begin
                        r_state <= PS_SKID;
                    end
                end
                default: begin
                    r_state <= PS_EMPTY;
                    r_main  <= '0;
                    r_skid  <= '0;
                end
            endcase
        end
    end

endmodule
